// File: rtl/if_fetch_ctrl_if.sv
// Fetch-controller bus bundle: prefetch handshake, redirect input,
// decode-side registered outputs and the delivered-instruction counter.
interface if_fetch_ctrl_if;
  // prefetch side
  logic [31:0] pf_instr_i;
  logic        pf_ack_i;
  logic        pf_stall_i;
  logic        if2pf_req_o;
  logic [31:0] if2pf_pc_ff_o;
  logic        if2pf_is_comp_o;
  logic        if2pf_clear_o;
  // redirect (branch / jump / trap)
  logic        redir_req_i;
  logic [31:0] redir_pc_i;
  // decode side
  logic        id_stall_i;
  logic        if2id_valid_o;
  logic [31:0] if2id_instr_o;
  logic [31:0] if2id_pc_o;
  logic        if2id_is_comp_o;
  // statistics
  logic [31:0] fetch_cnt_o;

  // Fetch controller view
  modport master (
    input  pf_instr_i, pf_ack_i, pf_stall_i,
    input  redir_req_i, redir_pc_i, id_stall_i,
    output if2pf_req_o, if2pf_pc_ff_o, if2pf_is_comp_o, if2pf_clear_o,
    output if2id_valid_o, if2id_instr_o, if2id_pc_o, if2id_is_comp_o,
    output fetch_cnt_o
  );

  // Environment view (prefetch, decode, redirect source)
  modport slave (
    output pf_instr_i, pf_ack_i, pf_stall_i,
    output redir_req_i, redir_pc_i, id_stall_i,
    input  if2pf_req_o, if2pf_pc_ff_o, if2pf_is_comp_o, if2pf_clear_o,
    input  if2id_valid_o, if2id_instr_o, if2id_pc_o, if2id_is_comp_o,
    input  fetch_cnt_o
  );
endinterface

// File: rtl/if_fetch_ctrl.sv
// Instruction-fetch controller: tracks the fetch PC, handshakes with the
// prefetch FIFO, decodes the compressed flag and registers the
// instruction towards decode. Redirects flush the FIFO via a one-cycle
// CLEAR state.
module if_fetch_ctrl #(
  parameter logic [31:0] RESET_VEC = 32'h8000_0000
) (
  input logic             clk,
  input logic             rst_n,
  if_fetch_ctrl_if.master bus
);

  typedef enum logic [1:0] {
    CLEAR = 2'd0,
    FILL  = 2'd1,
    RUN   = 2'd2
  } state_e;

  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

  state_e      state_q, state_d;
  logic [31:0] pc_ff_q, pc_ff_d;
  logic        valid_q, valid_d;
  logic [31:0] instr_q, instr_d;
  logic [31:0] pc_q, pc_d;
  logic        comp_q, comp_d;
  logic [31:0] cnt_q, cnt_d;

  logic        is_comp;
  logic        accept;

  // Compressed flag and accept decision; both feed the same-cycle FIFO shift
  always_comb begin
    is_comp = bus.pf_ack_i && (bus.pf_instr_i[1:0] != 2'b11);
    accept  = (state_q == RUN) && bus.pf_ack_i && !bus.id_stall_i && !bus.redir_req_i;
  end

  // Next-state / datapath: redirect beats decode stall, which beats accept
  always_comb begin
    state_d = state_q;
    pc_ff_d = pc_ff_q;
    valid_d = valid_q;
    instr_d = instr_q;
    pc_d    = pc_q;
    comp_d  = comp_q;
    cnt_d   = cnt_q;

    unique case (state_q)
      CLEAR:   state_d = FILL;
      FILL:    if (!bus.pf_stall_i) state_d = RUN;
      RUN:     if (bus.pf_stall_i) state_d = FILL;
      default: state_d = CLEAR;
    endcase

    if (bus.redir_req_i) begin
      // Bit 0 is dropped so the fetch PC stays halfword aligned
      state_d = CLEAR;
      pc_ff_d = {bus.redir_pc_i[31:1], 1'b0};
      valid_d = 1'b0;
    end else if (bus.id_stall_i) begin
      // Decode is full: everything facing decode and the PC freeze
      valid_d = valid_q;
    end else if (accept) begin
      pc_ff_d = pc_ff_q + (is_comp ? 32'd2 : 32'd4);
      valid_d = 1'b1;
      pc_d    = pc_ff_q;
      comp_d  = is_comp;
      instr_d = is_comp ? {16'h0000, bus.pf_instr_i[15:0]} : bus.pf_instr_i;
      cnt_d   = cnt_q + 32'd1;
    end else begin
      valid_d = 1'b0;
    end
  end

  // State and datapath registers with asynchronous reset
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= CLEAR;
      pc_ff_q <= RESET_VEC;
      valid_q <= 1'b0;
      instr_q <= NOP_INSTR;
      pc_q    <= 32'h0000_0000;
      comp_q  <= 1'b0;
      cnt_q   <= 32'h0000_0000;
    end else begin
      state_q <= state_d;
      pc_ff_q <= pc_ff_d;
      valid_q <= valid_d;
      instr_q <= instr_d;
      pc_q    <= pc_d;
      comp_q  <= comp_d;
      cnt_q   <= cnt_d;
    end
  end

  // Output mapping; request is withheld in CLEAR so no stale PC is captured
  always_comb begin
    bus.if2pf_clear_o   = (state_q == CLEAR);
    bus.if2pf_req_o     = (state_q != CLEAR);
    bus.if2pf_pc_ff_o   = pc_ff_q;
    bus.if2pf_is_comp_o = is_comp;
    bus.if2id_valid_o   = valid_q;
    bus.if2id_instr_o   = instr_q;
    bus.if2id_pc_o      = pc_q;
    bus.if2id_is_comp_o = comp_q;
    bus.fetch_cnt_o     = cnt_q;
  end

endmodule

// File: tb/tb_if_fetch_ctrl.sv
// Directed bench for if_fetch_ctrl with an expected-result queue.
module tb_if_fetch_ctrl;

  localparam int M_CLEAR = 0;
  localparam int M_FILL  = 1;
  localparam int M_RUN   = 2;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
    logic        comp;
  } exp_t;

  logic clk;
  logic rst_n;
  if_fetch_ctrl_if bus ();

  if_fetch_ctrl #(.RESET_VEC(32'h8000_0000)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.master)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int   checks = 0;
  int   errors = 0;
  exp_t exp_q[$];
  exp_t cur;
  int          m_state;
  logic [31:0] m_pc;
  logic [31:0] m_cnt;
  logic        m_valid;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_state   = M_CLEAR;
    m_pc      = 32'h8000_0000;
    m_cnt     = 32'h0;
    m_valid   = 1'b0;
    cur.pc    = 32'h0;
    cur.instr = 32'h0000_0013;
    cur.comp  = 1'b0;
    exp_q.delete();
  endtask

  task automatic check_all(input string tag);
    check({tag, "_valid"}, {31'h0, bus.if2id_valid_o}, {31'h0, m_valid});
    check({tag, "_id_pc"}, bus.if2id_pc_o, cur.pc);
    check({tag, "_id_instr"}, bus.if2id_instr_o, cur.instr);
    check({tag, "_id_comp"}, {31'h0, bus.if2id_is_comp_o}, {31'h0, cur.comp});
    check({tag, "_pc_ff"}, bus.if2pf_pc_ff_o, m_pc);
    check({tag, "_cnt"}, bus.fetch_cnt_o, m_cnt);
    check({tag, "_clear"}, {31'h0, bus.if2pf_clear_o}, {31'h0, (m_state == M_CLEAR)});
    check({tag, "_req"}, {31'h0, bus.if2pf_req_o}, {31'h0, (m_state != M_CLEAR)});
  endtask

  // One clock of stimulus: drive, check combinational flag, predict, clock, compare
  task automatic step(input logic ack, input logic [31:0] instr, input logic pstall,
                      input logic idst, input logic redir, input logic [31:0] rpc,
                      input string tag);
    logic comp;
    logic acc;
    logic fresh;
    exp_t e;
    bus.pf_ack_i    = ack;
    bus.pf_instr_i  = instr;
    bus.pf_stall_i  = pstall;
    bus.id_stall_i  = idst;
    bus.redir_req_i = redir;
    bus.redir_pc_i  = rpc;
    #1;
    comp = ack && (instr[1:0] != 2'b11);
    check({tag, "_is_comp"}, {31'h0, bus.if2pf_is_comp_o}, {31'h0, comp});
    acc   = (m_state == M_RUN) && ack && !idst && !redir;
    fresh = 1'b0;
    if (acc) begin
      e.pc    = m_pc;
      e.instr = comp ? {16'h0000, instr[15:0]} : instr;
      e.comp  = comp;
      exp_q.push_back(e);
    end
    if (redir) begin
      m_pc    = {rpc[31:1], 1'b0};
      m_valid = 1'b0;
    end else if (idst) begin
      m_valid = m_valid;
    end else if (acc) begin
      m_pc    = m_pc + (comp ? 32'd2 : 32'd4);
      m_valid = 1'b1;
      m_cnt   = m_cnt + 32'd1;
      fresh   = 1'b1;
    end else begin
      m_valid = 1'b0;
    end
    if (redir) m_state = M_CLEAR;
    else if (m_state == M_CLEAR) m_state = M_FILL;
    else if (m_state == M_FILL && !pstall) m_state = M_RUN;
    else if (m_state == M_RUN && pstall) m_state = M_FILL;
    @(posedge clk);
    #1;
    if (fresh) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $error("FAIL %s_underflow observed=empty expected=entry", tag);
      end else begin
        cur = exp_q.pop_front();
      end
    end
    check_all(tag);
    $display("step %s: valid=%0b id_pc=%h id_instr=%h pc_ff=%h cnt=%0d", tag,
             bus.if2id_valid_o, bus.if2id_pc_o, bus.if2id_instr_o,
             bus.if2pf_pc_ff_o, bus.fetch_cnt_o);
  endtask

  // Watchdog so a broken design can never hang the run
  initial begin
    #100000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst_n          = 1'b0;
    bus.pf_ack_i   = 1'b0;
    bus.pf_instr_i = 32'h0;
    bus.pf_stall_i = 1'b1;
    bus.id_stall_i = 1'b0;
    bus.redir_req_i = 1'b0;
    bus.redir_pc_i = 32'h0;
    model_reset();
    #12;
    check_all("reset");

    // Release just after an edge: the next cycle is cycle 0 (CLEAR)
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    #1;
    check_all("cycle0");

    step(1'b0, 32'h0, 1'b1, 1'b0, 1'b0, 32'h0, "to_fill");
    step(1'b1, 32'h0000_0013, 1'b0, 1'b0, 1'b0, 32'h0, "fill_ack_ignored");

    // Three full-width NOPs
    for (int i = 0; i < 3; i++)
      step(1'b1, 32'h0000_0013, 1'b0, 1'b0, 1'b0, 32'h0, $sformatf("nop%0d", i));

    step(1'b0, 32'hABCD_4501, 1'b0, 1'b0, 1'b0, 32'h0, "no_ack");
    step(1'b1, 32'hABCD_4501, 1'b0, 1'b0, 1'b0, 32'h0, "compressed");
    step(1'b1, 32'h00A0_0093, 1'b0, 1'b0, 1'b0, 32'h0, "full_after_comp");

    // FIFO stall: accept on the last RUN cycle, none while in FILL
    step(1'b1, 32'h0000_0013, 1'b1, 1'b0, 1'b0, 32'h0, "run_to_fill");
    step(1'b1, 32'h0000_0013, 1'b1, 1'b0, 1'b0, 32'h0, "fill_stalled");
    step(1'b1, 32'h0000_0013, 1'b0, 1'b0, 1'b0, 32'h0, "fill_to_run");

    // Decode stall for three cycles with ack, then release
    for (int i = 0; i < 3; i++)
      step(1'b1, 32'h1234_5677, 1'b0, 1'b1, 1'b0, 32'h0, $sformatf("id_stall%0d", i));
    step(1'b1, 32'h1234_5677, 1'b0, 1'b0, 1'b0, 32'h0, "id_release");

    // Redirect with ack and odd target
    step(1'b1, 32'h0000_0013, 1'b0, 1'b0, 1'b1, 32'h8000_0103, "redirect");
    step(1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0, "redir_fill");
    step(1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0, "redir_run");
    step(1'b1, 32'h0000_0013, 1'b0, 1'b0, 1'b0, 32'h0, "redir_target");

    // Redirect beats decode stall; PC wraps at 2^32
    step(1'b1, 32'h0000_0013, 1'b0, 1'b1, 1'b1, 32'hFFFF_FFFE, "redir_over_stall");
    step(1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0, "wrap_fill");
    step(1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0, "wrap_run");
    step(1'b1, 32'h0000_8082, 1'b0, 1'b0, 1'b0, 32'h0, "pc_wrap");

    // Counter wrap: preload all-ones between edges, then one accept
    force dut.cnt_q = 32'hFFFF_FFFF;
    #1;
    release dut.cnt_q;
    #1;
    m_cnt = 32'hFFFF_FFFF;
    check("cnt_preload", bus.fetch_cnt_o, m_cnt);
    step(1'b1, 32'h0000_0013, 1'b0, 1'b0, 1'b0, 32'h0, "cnt_wrap");

    // Reset in the middle of a cycle that would otherwise accept
    bus.pf_ack_i   = 1'b1;
    bus.pf_instr_i = 32'h0000_0013;
    #2;
    rst_n = 1'b0;
    #1;
    model_reset();
    check_all("mid_reset");
    @(posedge clk);
    #1;
    check_all("mid_reset_held");
    rst_n = 1'b1;
    #1;
    check_all("rerelease_cycle0");
    step(1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0, "re_fill");
    step(1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0, "re_run");
    step(1'b1, 32'h0000_0013, 1'b0, 1'b0, 1'b0, 32'h0, "re_first");

    check("queue_drained", exp_q.size(), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/if_fetch_ctrl.md
IF_FETCH_CTRL -- requirements
Module: if_fetch_ctrl

Interface
REQ-001 SHALL have parameter RESET_VEC, default 32'h8000_0000, which is the PC loaded on reset.
REQ-002 SHALL have port clk, input, 1 bit: single clock, all state on its rising edge.
REQ-003 SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-004 SHALL have port pf_instr_i, input, 32 bits: halfword-aligned instruction word from prefetch.
REQ-005 SHALL have port pf_ack_i, input, 1 bit: pf_instr_i is valid for pc_ff_o this cycle.
REQ-006 SHALL have port pf_stall_i, input, 1 bit: prefetch FIFO not yet full.
REQ-007 SHALL have port if2pf_req_o, output, 1 bit: fetch request to prefetch.
REQ-008 SHALL have port if2pf_pc_ff_o, output, 32 bits: current fetch PC; bit0 is always 0.
REQ-009 SHALL have port if2pf_is_comp_o, output, 1 bit: the current word is a compressed instruction.
REQ-010 SHALL have port if2pf_clear_o, output, 1 bit: flush the prefetch FIFO.
REQ-011 SHALL have port redir_req_i, input, 1 bit: redirect request (branch, jump, trap).
REQ-012 SHALL have port redir_pc_i, input, 32 bits: redirect target.
REQ-013 SHALL have port id_stall_i, input, 1 bit: decode cannot accept.
REQ-014 SHALL have port if2id_valid_o, output, 1 bit: registered instruction valid to decode.
REQ-015 SHALL have port if2id_instr_o, output, 32 bits: registered instruction to decode.
REQ-016 SHALL have port if2id_pc_o, output, 32 bits: registered PC of that instruction.
REQ-017 SHALL have port if2id_is_comp_o, output, 1 bit: registered compressed flag.
REQ-018 SHALL have port fetch_cnt_o, output, 32 bits: count of instructions delivered to decode.

Function
REQ-019 SHALL implement FSM states CLEAR, FILL, RUN.
- CLEAR: clear=1, req=0; always goes to FILL next cycle.
- FILL: req=1; goes to RUN when pf_stall_i=0.
- RUN: req=1; goes back to FILL when pf_stall_i=1.
REQ-020 SHALL compute is_comp_o combinationally as pf_ack_i AND (pf_instr_i[1:0] != 2'b11), so the same cycle's FIFO shift decision sees it.
REQ-021 SHALL define "accept" as state RUN AND pf_ack_i AND NOT id_stall_i AND NOT redir_req_i.
REQ-022 SHALL, on accept, advance pc_ff by 2 when is_comp, otherwise by 4; 32-bit modulo addition, wrapping at 2^32.
REQ-023 SHALL, on accept, register the following:
- if2id_valid=1;
- if2id_pc = the pre-advance pc_ff;
- if2id_is_comp = is_comp;
- if2id_instr = {16'h0, instr[15:0]} when compressed, otherwise instr.
REQ-024 SHALL, in RUN/FILL with NOT redir_req_i AND NOT id_stall_i AND no accept, register if2id_valid=0; the other if2id_* fields hold.
REQ-025 SHALL, while id_stall_i=1 and no redirect, hold pc_ff and all if2id_* outputs unchanged.
REQ-026 SHALL, on redir_req_i=1 in any state:
- load pc_ff with {redir_pc_i[31:1], 1'b0};
- set if2id_valid=0 next cycle;
- enter CLEAR.
REQ-027 SHALL give redirect priority over accept and over id_stall_i in the same cycle.
REQ-028 SHALL increment fetch_cnt by 1 on each accept, wrapping 32'hFFFF_FFFF to 0.
REQ-029 SHALL drive if2pf_req_o=0 in CLEAR, so the FIFO never captures a stale PC.

Reset
REQ-030 SHALL, while rst_n=0, asynchronously set:
- state=CLEAR, pc_ff=RESET_VEC;
- if2id_valid=0, if2id_instr=32'h0000_0013 (NOP), if2id_pc=0, if2id_is_comp=0;
- fetch_cnt=0.
REQ-031 SHALL, after rst_n release, drive clear=1 for exactly one cycle, then enter FILL.
REQ-032 SHALL, on reset asserted mid-operation, discard any pending accept and return to the reset state.

Verification
REQ-033 Reset release -> cycle 0: clear=1, req=0, pc_ff=0x8000_0000; cycle 1: req=1; if2id_valid=0 until the first ack in RUN.
REQ-034 RUN, ack with instr 0x0000_0013 three cycles -> if2id_pc 0x8000_0000, 0x8000_0004, 0x8000_0008; fetch_cnt=3.
REQ-035 RUN, ack with instr 0xABCD_4501 -> is_comp=1 same cycle, if2id_instr=0x0000_4501, pc_ff advances by 2 to 0x8000_0002.
REQ-036 Redirect to 0x8000_0103 in a cycle with ack -> no accept, pc_ff=0x8000_0102, one-cycle clear, if2id_valid=0, fetch_cnt unchanged.
REQ-037 id_stall_i=1 for 3 cycles during RUN with ack -> pc_ff and if2id_* constant; one accept after release.
REQ-038 fetch_cnt preloaded 0xFFFF_FFFF (force) plus one accept -> fetch_cnt=0.
